parallel_to_serial: RTL and testbench

- Splits an N-bit parallel word into N/8 bytes and presents them most-significant byte first to a byte-wide UART transmitter.
- Each byte is issued as a one-cycle tx_valid strobe.
- After the first byte, each next byte is issued only after the transmitter's is_transmitting flag falls (previous byte finished).
- Sits between the datapath result register and the UART TX core.

---
 rtl/parallel_to_serial.sv | 90 +++++++++
 tb/tb_parallel_to_serial.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// Serialises an N-bit result word into N/8 bytes, MSB first, for a byte-wide UART TX core.
// Each byte is a one-cycle tx_valid strobe; later bytes wait for the transmitter's busy flag to fall.
module parallel_to_serial #(
  parameter int N         = 32,
  parameter int Ndiv4log2 = 3
) (
  input  logic         iCE_CLK,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_bytes,
  input  logic         is_transmitting,
  output logic [7:0]   tx_byte,
  output logic         tx_valid
);

  localparam int NBYTES = N / 8;
  localparam logic [Ndiv4log2-1:0] LAST_COUNT = Ndiv4log2'(NBYTES);
  localparam logic [Ndiv4log2-1:0] ONE        = Ndiv4log2'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } state_t;

  state_t               state;
  logic [N-1:0]         shreg;
  logic [Ndiv4log2-1:0] count;
  logic                 rx_valid_q;
  logic                 is_transmitting_q;
  logic                 rx_rise;
  logic                 tx_fall;

  // rx_valid_q clears on reset, so a word already presented at reset release still loads.
  assign rx_rise = rx_valid & ~rx_valid_q;
  assign tx_fall = ~is_transmitting & is_transmitting_q;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      shreg             <= '0;
      count             <= '0;
      rx_valid_q        <= 1'b0;
      is_transmitting_q <= 1'b0;
      tx_byte           <= 8'h00;
      tx_valid          <= 1'b0;
    end else begin
      rx_valid_q        <= rx_valid;
      is_transmitting_q <= is_transmitting;
      tx_valid          <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_rise) begin
            tx_byte  <= rx_bytes[N-1 -: 8];
            tx_valid <= 1'b1;
            shreg    <= rx_bytes << 8;
            count    <= ONE;
            state    <= (NBYTES > 1) ? SEND : DRAIN;
          end
        end

        SEND: begin
          // Only a busy-flag falling edge advances; rx activity is ignored mid-word.
          if (tx_fall) begin
            tx_byte  <= shreg[N-1 -: 8];
            tx_valid <= 1'b1;
            shreg    <= shreg << 8;
            count    <= count + ONE;
            if (count + ONE == LAST_COUNT) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Last byte is on the wire; return to IDLE once it completes.
          if (tx_fall) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: directed protocol scenarios plus randomized words
// compared against a byte-order model computed from the word value.
module tb_parallel_to_serial;

  localparam int N  = 32;
  localparam int NB = N / 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_valid;
  logic [N-1:0] rx_bytes;
  logic         is_transmitting;
  logic [7:0]   tx_byte;
  logic         tx_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(.N(N), .Ndiv4log2(3)) dut (
    .iCE_CLK        (clk),
    .rst_n          (rst_n),
    .rx_valid       (rx_valid),
    .rx_bytes       (rx_bytes),
    .is_transmitting(is_transmitting),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid)
  );

  // Byte k of a word in transmit order (k=0 is the most significant byte).
  function automatic logic [7:0] model_byte(input logic [N-1:0] w, input int k);
    logic [N-1:0] s;
    s = w >> (8 * (NB - 1 - k));
    return s[7:0];
  endfunction

  // Busy high for hi cycles, then low; returns at the negedge where a resulting strobe is visible.
  task automatic pulse_tx(input int hi);
    is_transmitting = 1'b1;
    repeat (hi) @(negedge clk);
    is_transmitting = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; is_transmitting = 1'b0; rx_bytes = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++;
    if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", tx_valid); end
  endtask

  task automatic test_directed_word;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hCC; exp_b[1] = 8'hBB; exp_b[2] = 8'hAA;
    rx_bytes = 32'hDDCCBBAA; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'hDD) begin
      errors++; $display("FAIL first_byte: got v=%b b=%h expected v=1 b=dd", tx_valid, tx_byte);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0 || tx_byte !== 8'hDD) begin
        errors++; $display("FAIL first_byte_hold: got v=%b b=%h expected v=0 b=dd", tx_valid, tx_byte);
      end
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tx(1);
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[i]) begin
        errors++; $display("FAIL next_byte%0d: got v=%b b=%h expected v=1 b=%h", i, tx_valid, tx_byte, exp_b[i]);
      end
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_strobe%0d: got %b expected 0", i, tx_valid); end
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_wait: got %b expected 0", tx_valid); end
    end
    pulse_tx(1);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_exit_strobe: got %b expected 0", tx_valid); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL held_rx_retrigger: got %b expected 0", tx_valid); end
    end
    rx_valid = 1'b0;
    @(negedge clk);
    rx_bytes = 32'h01020304; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h01) begin
      errors++; $display("FAIL reload_after_idle: got v=%b b=%h expected v=1 b=01", tx_valid, tx_byte);
    end
    repeat (NB) pulse_tx(1);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_reload;
    logic [N-1:0] w;
    w = 32'hA1B2C3D4;
    rx_bytes = w; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_byte !== 8'hA1 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL ignore_first: got v=%b b=%h expected v=1 b=a1", tx_valid, tx_byte);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    rx_bytes = 32'h11223344; rx_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reload_in_send: got %b expected 0", tx_valid); end
    for (int k = 1; k < NB; k++) begin
      pulse_tx(1);
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== model_byte(w, k)) begin
        errors++; $display("FAIL ignore_byte%0d: got v=%b b=%h expected v=1 b=%h", k, tx_valid, tx_byte, model_byte(w, k));
      end
    end
    pulse_tx(1);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    rx_bytes = 32'hDDCCBBAA; rx_valid = 1'b1;
    @(negedge clk);
    pulse_tx(1);
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'hCC) begin
      errors++; $display("FAIL mid_pre_reset: got v=%b b=%h expected v=1 b=cc", tx_valid, tx_byte);
    end
    rst_n = 1'b0; rx_valid = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
      errors++; $display("FAIL async_reset: got v=%b b=%h expected v=0 b=00", tx_valid, tx_byte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      pulse_tx(1);
      checks++;
      if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
        errors++; $display("FAIL aborted_word%0d: got v=%b b=%h expected v=0 b=00", i, tx_valid, tx_byte);
      end
    end
  endtask

  task automatic test_hold_low;
    logic [N-1:0] w;
    int strobes;
    w = $urandom;
    rx_bytes = w; rx_valid = 1'b1;
    @(negedge clk);
    strobes = 0;
    if (tx_valid === 1'b1) strobes++;
    for (int k = 1; k < NB; k++) begin
      repeat (10) begin
        @(negedge clk);
        if (tx_valid === 1'b1) strobes++;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL hold_low_advance: got %b expected 0", tx_valid); end
      end
      pulse_tx(2);
      if (tx_valid === 1'b1) strobes++;
      checks++;
      if (tx_byte !== model_byte(w, k)) begin
        errors++; $display("FAIL hold_low_byte%0d: got %h expected %h", k, tx_byte, model_byte(w, k));
      end
    end
    pulse_tx(1);
    if (tx_valid === 1'b1) strobes++;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== NB) begin errors++; $display("FAIL strobe_count: got %0d expected %0d", strobes, NB); end
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_words;
    logic [N-1:0] w;
    int lo, hi;
    for (int n = 0; n < 20; n++) begin
      w = $urandom;
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rand_gap: got %b expected 0", tx_valid); end
      end
      rx_bytes = w; rx_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== model_byte(w, 0)) begin
        errors++; $display("FAIL rand_w%0d_b0: got v=%b b=%h expected v=1 b=%h", n, tx_valid, tx_byte, model_byte(w, 0));
      end
      for (int k = 1; k <= NB; k++) begin
        lo = $urandom_range(0, 3);
        hi = $urandom_range(1, 4);
        repeat (lo) begin
          @(negedge clk);
          checks++;
          if (tx_valid !== 1'b0) begin errors++; $display("FAIL rand_idle_low: got %b expected 0", tx_valid); end
        end
        is_transmitting = 1'b1;
        repeat (hi) begin
          if (k < NB && $urandom_range(0, 1) == 1) begin
            rx_valid = ~rx_valid;
            rx_bytes = $urandom;
          end
          @(negedge clk);
          checks++;
          if (tx_valid !== 1'b0) begin errors++; $display("FAIL rand_busy: got %b expected 0", tx_valid); end
        end
        if (k == NB) rx_valid = 1'b0;
        is_transmitting = 1'b0;
        @(negedge clk);
        checks++;
        if (k < NB) begin
          if (tx_valid !== 1'b1 || tx_byte !== model_byte(w, k)) begin
            errors++; $display("FAIL rand_w%0d_b%0d: got v=%b b=%h expected v=1 b=%h", n, k, tx_valid, tx_byte, model_byte(w, k));
          end
        end else if (tx_valid !== 1'b0) begin
          errors++; $display("FAIL rand_w%0d_drain: got %b expected 0", n, tx_valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_word();
    test_ignore_reload();
    test_reset_mid();
    test_hold_low();
    test_random_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
